// File: rtl/bcd_hex_display.sv
// Two-digit time-multiplexed seven-segment driver for a BCD word.
// A load strobe fills a shadow register; the shadow moves into the active
// (displayed) register only at a frame boundary so a frame never mixes values.
// The scan alternates units digit, blank gap, tens digit, blank gap.
module bcd_hex_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP         = 500,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       pending,
  output logic       err
);

  localparam int MAXC = (REFRESH_DIV > GAP) ? REFRESH_DIV : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DIG_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_UNITS  = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    GAP0 = 2'd1,
    DIG1 = 2'd2,
    GAP1 = 2'd3
  } scan_state_e;

  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] active_q, active_d;
  logic pending_q, pending_d;
  logic err_q, err_d;
  logic [6:0] seg_q, seg_d;
  logic [1:0] an_q, an_d;

  logic slotLast;
  logic frameEdge;

  // Active-low segment pattern for one digit; anything above 9 shows 'E'.
  function automatic logic [6:0] segPattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0: pat = 7'b1000000;
      4'd1: pat = 7'b1111001;
      4'd2: pat = 7'b0100100;
      4'd3: pat = 7'b0110000;
      4'd4: pat = 7'b0011001;
      4'd5: pat = 7'b0010010;
      4'd6: pat = 7'b0000010;
      4'd7: pat = 7'b1111000;
      4'd8: pat = 7'b0000000;
      4'd9: pat = 7'b0010000;
      default: pat = SEG_E;
    endcase
    return pat;
  endfunction

  // Scan sequencing: count out each slot, then advance and clear the counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    slotLast = ((state_q == DIG0) || (state_q == DIG1)) ? (cnt_q == DIG_LAST)
                                                        : (cnt_q == GAP_LAST);
    if (slotLast) begin
      cnt_d = '0;
      case (state_q)
        DIG0:    state_d = GAP0;
        GAP0:    state_d = DIG1;
        DIG1:    state_d = GAP1;
        default: state_d = DIG0;
      endcase
    end
    frameEdge = (state_q == GAP1) && slotLast;
  end

  // Double buffering: the pre-edge shadow transfers at the frame edge while a
  // coincident load still lands in the shadow and keeps pending high.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frameEdge && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end
    err_d = (active_d[7:4] > 4'd9) || (active_d[3:0] > 4'd9);
  end

  // Registered display outputs derived from the upcoming state and value so
  // they change on the same edge as the scan or the displayed value.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    case (state_d)
      DIG0: begin
        seg_d = segPattern(active_d[3:0]);
        an_d  = AN_UNITS;
      end
      DIG1: begin
        if (!(BLANK_LZ && (active_d[7:4] == 4'd0))) begin
          seg_d = segPattern(active_d[7:4]);
          an_d  = AN_TENS;
        end
      end
      default: begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset parks the scan in
  // the last gap so the first frame starts after one blank gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= GAP1;
      cnt_q     <= '0;
      shadow_q  <= 8'h00;
      active_q  <= 8'h00;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign pending = pending_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_hex_display.sv
// Testbench for bcd_hex_display: two instances (leading-zero blanking on and
// off) share the inputs; a frame-phase model predicts every cycle's outputs.
module tb_bcd_hex_display;

  localparam int RDIV  = 4;
  localparam int GAPC  = 2;
  localparam int FRAME = 2 * (RDIV + GAPC);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic [7:0] bcd_in = 8'h00;

  logic [6:0] segLz, segNl;
  logic [1:0] anLz, anNl;
  logic pendLz, pendNl, errLz, errNl;

  typedef struct packed {
    logic [6:0] segLz;
    logic [1:0] anLz;
    logic [6:0] segNl;
    logic [1:0] anNl;
    logic       pending;
    logic       err;
  } expect_t;

  expect_t sbQ[$];

  int compCount = 0;
  int failCount = 0;

  int mPh = 0;
  logic [7:0] mShadow = 8'h00;
  logic [7:0] mActive = 8'h00;
  logic mPending = 1'b0;

  bcd_hex_display #(.REFRESH_DIV(RDIV), .GAP(GAPC), .BLANK_LZ(1'b1)) dutLz (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .seg(segLz), .an(anLz), .pending(pendLz), .err(errLz)
  );

  bcd_hex_display #(.REFRESH_DIV(RDIV), .GAP(GAPC), .BLANK_LZ(1'b0)) dutNoLz (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .seg(segNl), .an(anNl), .pending(pendNl), .err(errNl)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] digitSeg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'b1000000;
      4'd1: p = 7'b1111001;
      4'd2: p = 7'b0100100;
      4'd3: p = 7'b0110000;
      4'd4: p = 7'b0011001;
      4'd5: p = 7'b0010010;
      4'd6: p = 7'b0000010;
      4'd7: p = 7'b1111000;
      4'd8: p = 7'b0000000;
      4'd9: p = 7'b0010000;
      default: p = 7'b0000110;
    endcase
    return p;
  endfunction

  function automatic expect_t predict();
    expect_t e;
    e.segLz   = 7'h7F;
    e.anLz    = 2'b11;
    e.segNl   = 7'h7F;
    e.anNl    = 2'b11;
    e.pending = mPending;
    e.err     = (mActive[7:4] > 4'd9) || (mActive[3:0] > 4'd9);
    if (mPh < RDIV) begin
      e.segLz = digitSeg(mActive[3:0]);
      e.anLz  = 2'b10;
      e.segNl = digitSeg(mActive[3:0]);
      e.anNl  = 2'b10;
    end else if (mPh >= RDIV + GAPC && mPh < 2 * RDIV + GAPC) begin
      e.segNl = digitSeg(mActive[7:4]);
      e.anNl  = 2'b01;
      if (mActive[7:4] != 4'd0) begin
        e.segLz = digitSeg(mActive[7:4]);
        e.anLz  = 2'b01;
      end
    end
    return e;
  endfunction

  task automatic modelEdge(input logic r, input logic ld, input logic [7:0] v);
    if (!r) begin
      mPh      = 2 * RDIV + GAPC;
      mShadow  = 8'h00;
      mActive  = 8'h00;
      mPending = 1'b0;
    end else begin
      mPh = (mPh + 1) % FRAME;
      if (mPh == 0 && mPending) begin
        mActive  = mShadow;
        mPending = 1'b0;
      end
      if (ld) begin
        mShadow  = v;
        mPending = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: observed %h required %h", tag, $time,
               observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic [7:0] v);
    expect_t e;
    rst_n  = r;
    load   = ld;
    bcd_in = v;
    modelEdge(r, ld, v);
    sbQ.push_back(predict());
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput("sb_empty", 8'h00, 8'h01);
    end else begin
      e = sbQ.pop_front();
      checkOutput("sb_seg_lz",  8'(segLz),  8'(e.segLz));
      checkOutput("sb_an_lz",   8'(anLz),   8'(e.anLz));
      checkOutput("sb_seg_nl",  8'(segNl),  8'(e.segNl));
      checkOutput("sb_an_nl",   8'(anNl),   8'(e.anNl));
      checkOutput("sb_pend_lz", 8'(pendLz), 8'(e.pending));
      checkOutput("sb_pend_nl", 8'(pendNl), 8'(e.pending));
      checkOutput("sb_err_lz",  8'(errLz),  8'(e.err));
      checkOutput("sb_err_nl",  8'(errNl),  8'(e.err));
    end
  endtask

  task automatic runTo(input int target);
    int n;
    n = 0;
    while (mPh != target && n < FRAME) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      n++;
    end
  endtask

  initial begin
    // Reset and idle
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkOutput("rst_seg", 8'(segLz), 8'h7F);
    checkOutput("rst_an", 8'(anLz), 8'h03);
    checkOutput("rst_pend", 8'(pendLz), 8'h00);
    checkOutput("rst_err", 8'(errLz), 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("gap_after_rst_an", 8'(anLz), 8'h03);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("idle_dig0_seg", 8'(segLz), 8'h40);
    checkOutput("idle_dig0_an", 8'(anLz), 8'h02);
    runTo(6);
    checkOutput("idle_dig1_an_lz", 8'(anLz), 8'h03);
    checkOutput("idle_dig1_seg_lz", 8'(segLz), 8'h7F);

    // Load 0x58 during DIG1
    applyStimulus(1'b1, 1'b1, 8'h58);
    checkOutput("l58_pend", 8'(pendLz), 8'h01);
    runTo(11);
    checkOutput("l58_pend_hold", 8'(pendLz), 8'h01);
    runTo(0);
    checkOutput("l58_pend_clr", 8'(pendLz), 8'h00);
    checkOutput("l58_units", 8'(segLz), 8'h00);
    checkOutput("l58_units_an", 8'(anLz), 8'h02);
    runTo(6);
    checkOutput("l58_tens", 8'(segLz), 8'h12);
    checkOutput("l58_tens_an", 8'(anLz), 8'h01);

    // Leading zero
    applyStimulus(1'b1, 1'b1, 8'h07);
    runTo(0);
    checkOutput("l07_units", 8'(segLz), 8'h78);
    runTo(6);
    checkOutput("l07_tens_an_lz", 8'(anLz), 8'h03);
    checkOutput("l07_tens_seg_lz", 8'(segLz), 8'h7F);
    checkOutput("l07_tens_an_nl", 8'(anNl), 8'h01);
    checkOutput("l07_tens_seg_nl", 8'(segNl), 8'h40);

    // Invalid digit, then recovery
    applyStimulus(1'b1, 1'b1, 8'h3C);
    runTo(0);
    checkOutput("l3c_err", 8'(errLz), 8'h01);
    checkOutput("l3c_units_e", 8'(segLz), 8'h06);
    runTo(6);
    checkOutput("l3c_tens", 8'(segLz), 8'h30);
    applyStimulus(1'b1, 1'b1, 8'h21);
    runTo(11);
    checkOutput("l21_err_hold", 8'(errLz), 8'h01);
    runTo(0);
    checkOutput("l21_err_clr", 8'(errLz), 8'h00);
    checkOutput("l21_units", 8'(segLz), 8'h79);

    // Overwrite within one frame: last load wins
    applyStimulus(1'b1, 1'b1, 8'h12);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h34);
    runTo(0);
    checkOutput("ovw_units", 8'(segLz), 8'h19);
    runTo(6);
    checkOutput("ovw_tens", 8'(segLz), 8'h30);

    // Load coinciding with the frame boundary
    applyStimulus(1'b1, 1'b1, 8'h56);
    runTo(11);
    applyStimulus(1'b1, 1'b1, 8'h99);
    checkOutput("coin_units_old", 8'(segLz), 8'h02);
    checkOutput("coin_pend", 8'(pendLz), 8'h01);
    runTo(6);
    checkOutput("coin_tens_old", 8'(segLz), 8'h12);
    runTo(0);
    checkOutput("coin_units_new", 8'(segLz), 8'h10);
    checkOutput("coin_pend_clr", 8'(pendLz), 8'h00);

    // Reset mid-scan with pending data
    runTo(5);
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("mid_pend", 8'(pendLz), 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("mid_rst_an", 8'(anLz), 8'h03);
    checkOutput("mid_rst_seg", 8'(segLz), 8'h7F);
    checkOutput("mid_rst_pend", 8'(pendLz), 8'h00);
    runTo(0);
    checkOutput("mid_rel_units", 8'(segLz), 8'h40);
    checkOutput("mid_rel_an", 8'(anLz), 8'h02);

    // Random traffic with occasional resets
    for (int i = 0; i < 120; i++) begin
      logic r;
      logic ld;
      r  = ($urandom_range(0, 39) != 0);
      ld = ($urandom_range(0, 4) == 0);
      applyStimulus(r, ld, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
